imm_gen_pipe: RTL and testbench

Parametrised, registered successor to the combinational immediate generator used in the decode path.
- Extracts and sign/zero-extends RISC-V immediates for XLEN of 32 or 64.
- Adds two formats: CSR uimm (Z) and shift amount (SH).
- Carries an opaque tag alongside each immediate.
- Sits between fetch/decode and the ID/EX register, with a valid/ready handshake and a one-entry skid buffer so upstream backpressure never drops an instruction.

---
 rtl/imm_pkg.sv | 18 +
 rtl/imm_extract.sv | 52 +++++
 rtl/imm_gen_pipe.sv | 126 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared constants for the pipelined immediate generator.
package imm_pkg;

    // Format select encodings for immgen_op
    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;
    localparam logic [2:0] IMM_Z    = 3'd6;
    localparam logic [2:0] IMM_SH   = 3'd7;

    // Supported datapath widths
    localparam int XLEN_32 = 32;
    localparam int XLEN_64 = 64;

endpackage

// File: rtl/imm_extract.sv
// Combinational RISC-V immediate extraction and extension for XLEN 32 or 64.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = XLEN_64
) (
    input  logic [31:0]     inst,
    input  logic [2:0]      immgen_op,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    // Built at 64 bits, then narrowed to XLEN
    logic [63:0] wide;

    // Opcode bits never feed any immediate
    logic unused_opcode;
    assign unused_opcode = ^inst[6:0];

    // Decode the selected format into a 64-bit sign/zero-extended value
    always_comb begin
        wide    = '0;
        illegal = 1'b0;
        case (immgen_op)
            IMM_I:  wide = {{52{inst[31]}}, inst[31:20]};
            IMM_S:  wide = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:  wide = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:  wide = {{32{inst[31]}}, inst[31:12], 12'b0};
            IMM_J:  wide = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_Z:  wide = {59'b0, inst[19:15]};
            IMM_SH: begin
                if (XLEN == XLEN_64) begin
                    wide = {58'b0, inst[25:20]};
                end else begin
                    // shamt[5] set is not a legal RV32 shift amount
                    wide    = {59'b0, inst[24:20]};
                    illegal = inst[25];
                end
            end
            default: wide = '0;
        endcase
    end

    if (XLEN == XLEN_64) begin : g_x64
        assign imm = wide;
    end else begin : g_x32
        logic unused_hi;
        assign unused_hi = ^wide[63:32];
        assign imm       = wide[31:0];
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake and optional skid entry.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN    = XLEN_64,
    parameter int TAG_W   = 8,
    parameter int SKID_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [2:0]       immgen_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    logic [XLEN-1:0]  ext_imm;
    logic             ext_illegal;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             ill_q, ill_d;

    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             skid_ill_q, skid_ill_d;

    logic             accept;
    logic             out_load;

    // Immediate is computed before registering so later inst changes cannot affect it
    imm_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .inst      (inst),
        .immgen_op (immgen_op),
        .imm       (ext_imm),
        .illegal   (ext_illegal)
    );

    // Upstream ready: skid mode only blocks when the skid entry is occupied
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (SKID_EN != 0) begin
                in_ready = !skid_valid_q;
            end else begin
                in_ready = !out_valid_q || out_ready;
            end
        end
    end

    assign accept   = in_valid && in_ready;
    assign out_load = !out_valid_q || out_ready;

    // Next state: output register refills from skid first, else from the new input
    always_comb begin
        out_valid_d  = out_valid_q;
        imm_d        = imm_q;
        tag_d        = tag_q;
        ill_d        = ill_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;
        skid_ill_d   = skid_ill_q;
        if (out_load) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                imm_d        = skid_imm_q;
                tag_d        = skid_tag_q;
                ill_d        = skid_ill_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                imm_d       = ext_imm;
                tag_d       = in_tag;
                ill_d       = ext_illegal;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Output stalled: park the accepted instruction in the skid entry
            skid_valid_d = 1'b1;
            skid_imm_d   = ext_imm;
            skid_tag_d   = in_tag;
            skid_ill_d   = ext_illegal;
        end
    end

    // State registers with synchronous reset discarding output and skid contents
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            imm_q        <= '0;
            tag_q        <= '0;
            ill_q        <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            skid_ill_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            imm_q        <= imm_d;
            tag_q        <= tag_d;
            ill_q        <= ill_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
            skid_ill_q   <= skid_ill_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign imm         = imm_q;
    assign out_tag     = tag_q;
    assign out_illegal = ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench: three instances (XLEN64 skid, XLEN32 skid, XLEN64 no-skid) against a queue model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] inst;
    logic [2:0]  op;
    logic [7:0]  tag;
    logic        out_ready_a [3];

    logic        rdy0, rdy1, rdy2, vld0, vld1, vld2, ill0, ill1, ill2;
    logic [63:0] imm0, imm2;
    logic [31:0] imm1;
    logic [7:0]  tag0, tag1, tag2;

    logic        in_ready_a  [3];
    logic        out_valid_a [3];
    logic        ill_a       [3];
    logic [63:0] imm_a       [3];
    logic [7:0]  tag_a       [3];

    int checks;
    int errors;
    bit sb_on;

    typedef struct {
        logic [63:0] imm;
        logic [7:0]  tag;
        logic        ill;
    } exp_t;
    exp_t q [3][$];

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  op;
        logic [63:0] e64;
        logic [31:0] e32;
        logic        i64;
        logic        i32;
    } vec_t;
    vec_t vecs [12];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .SKID_EN(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .inst(inst),
        .immgen_op(op), .in_tag(tag), .out_valid(vld0), .out_ready(out_ready_a[0]),
        .imm(imm0), .out_tag(tag0), .out_illegal(ill0)
    );
    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .SKID_EN(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .inst(inst),
        .immgen_op(op), .in_tag(tag), .out_valid(vld1), .out_ready(out_ready_a[1]),
        .imm(imm1), .out_tag(tag1), .out_illegal(ill1)
    );
    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .SKID_EN(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .inst(inst),
        .immgen_op(op), .in_tag(tag), .out_valid(vld2), .out_ready(out_ready_a[2]),
        .imm(imm2), .out_tag(tag2), .out_illegal(ill2)
    );

    always_comb begin
        in_ready_a[0]  = rdy0;  in_ready_a[1]  = rdy1;  in_ready_a[2]  = rdy2;
        out_valid_a[0] = vld0;  out_valid_a[1] = vld1;  out_valid_a[2] = vld2;
        ill_a[0]       = ill0;  ill_a[1]       = ill1;  ill_a[2]       = ill2;
        imm_a[0]       = imm0;  imm_a[1]       = {32'b0, imm1}; imm_a[2] = imm2;
        tag_a[0]       = tag0;  tag_a[1]       = tag1;  tag_a[2]       = tag2;
    end

    function automatic int xl(input int d);
        return (d == 1) ? 32 : 64;
    endfunction

    function automatic bit sk(input int d);
        return d != 2;
    endfunction

    // Reference immediate from field arithmetic: {illegal, imm}
    function automatic logic [64:0] ref_imm(input logic [31:0] i, input logic [2:0] o,
                                            input int xlen);
        longint s, v;
        logic   ill;
        s   = longint'($signed(i));
        v   = 0;
        ill = 1'b0;
        case (o)
            3'd1: v = s >>> 20;
            3'd2: begin v = s >>> 25; v = v * 32 + longint'(i[11:7]); end
            3'd3: begin
                v = s >>> 31;
                v = v * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
                    + longint'(i[11:8]) * 2;
            end
            3'd4: begin v = s >>> 12; v = v * 4096; end
            3'd5: begin
                v = s >>> 31;
                v = v * 1048576 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
                    + longint'(i[30:21]) * 2;
            end
            3'd6: v = longint'(i[19:15]);
            3'd7: begin
                if (xlen == 64) begin
                    v = longint'(i[25:20]);
                end else begin
                    v   = longint'(i[24:20]);
                    ill = i[25];
                end
            end
            default: v = 0;
        endcase
        if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return {ill, v};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model update: pop on take, push on accept (readiness from pre-edge occupancy)
    always @(posedge clk) begin
        if (sb_on) begin
            for (int d = 0; d < 3; d++) begin
                if (rst) begin
                    q[d].delete();
                end else begin
                    bit   mrdy;
                    exp_t e;
                    logic [64:0] r;
                    mrdy = sk(d) ? (q[d].size() < 2) : (q[d].size() == 0 || out_ready_a[d]);
                    if (q[d].size() > 0 && out_ready_a[d]) void'(q[d].pop_front());
                    if (in_valid && mrdy) begin
                        r     = ref_imm(inst, op, xl(d));
                        e.imm = r[63:0];
                        e.ill = r[64];
                        e.tag = tag;
                        q[d].push_back(e);
                    end
                end
            end
        end
    end

    // Compare every instance against the model away from the clock edge
    always @(negedge clk) begin
        if (sb_on) begin
            for (int d = 0; d < 3; d++) begin
                if (rst) begin
                    chk($sformatf("d%0d in_ready_in_reset", d), 64'(in_ready_a[d]), 64'd0);
                end else begin
                    bit mrdy;
                    mrdy = sk(d) ? (q[d].size() < 2) : (q[d].size() == 0 || out_ready_a[d]);
                    chk($sformatf("d%0d in_ready", d), 64'(in_ready_a[d]), 64'(mrdy));
                    chk($sformatf("d%0d out_valid", d), 64'(out_valid_a[d]),
                        64'(q[d].size() > 0));
                    if (q[d].size() > 0) begin
                        chk($sformatf("d%0d imm", d), imm_a[d], q[d][0].imm);
                        chk($sformatf("d%0d out_tag", d), 64'(tag_a[d]), 64'(q[d][0].tag));
                        chk($sformatf("d%0d out_illegal", d), 64'(ill_a[d]), 64'(q[d][0].ill));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] got [$];
        bit         drop;

        checks = 0;
        errors = 0;
        sb_on  = 1'b0;
        rst    = 1'b1;
        in_valid = 1'b0;
        inst   = '0;
        op     = '0;
        tag    = '0;
        for (int d = 0; d < 3; d++) out_ready_a[d] = 1'b0;

        vecs[0]  = '{32'hFFF0_0093, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[1]  = '{32'h8000_00B7, 3'd4, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 1'b0, 1'b0};
        vecs[2]  = '{32'hFE00_0EE3, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1'b0};
        vecs[3]  = '{32'h000F_8000, 3'd6, 64'd31, 32'd31, 1'b0, 1'b0};
        vecs[4]  = '{32'h0210_0000, 3'd7, 64'd33, 32'd1, 1'b0, 1'b1};
        vecs[5]  = '{32'h03F0_0000, 3'd7, 64'd63, 32'd31, 1'b0, 1'b1};
        vecs[6]  = '{32'hFFFF_FFFF, 3'd0, 64'd0, 32'd0, 1'b0, 1'b0};
        vecs[7]  = '{32'hFE00_0FA3, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[8]  = '{32'h8000_006F, 3'd5, 64'hFFFF_FFFF_FFF0_0000, 32'hFFF0_0000, 1'b0, 1'b0};
        vecs[9]  = '{32'h1234_5037, 3'd4, 64'h0000_0000_1234_5000, 32'h1234_5000, 1'b0, 1'b0};
        vecs[10] = '{32'h7FF0_0013, 3'd1, 64'h7FF, 32'h7FF, 1'b0, 1'b0};
        vecs[11] = '{32'h01F0_0000, 3'd7, 64'd31, 32'd31, 1'b0, 1'b0};

        step();
        sb_on = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d reset out_valid", d), 64'(out_valid_a[d]), 64'd0);
            chk($sformatf("d%0d reset imm", d), imm_a[d], 64'd0);
            chk($sformatf("d%0d reset out_tag", d), 64'(tag_a[d]), 64'd0);
            chk($sformatf("d%0d reset out_illegal", d), 64'(ill_a[d]), 64'd0);
        end
        step();

        // Directed format vectors, one at a time with downstream always ready
        for (int d = 0; d < 3; d++) out_ready_a[d] = 1'b1;
        foreach (vecs[k]) begin
            in_valid = 1'b1;
            inst     = vecs[k].inst;
            op       = vecs[k].op;
            tag      = 8'(k + 1);
            step();
            in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d x64 imm", k), imm0, vecs[k].e64);
            chk($sformatf("vec%0d x64 illegal", k), 64'(ill0), 64'(vecs[k].i64));
            chk($sformatf("vec%0d x32 imm", k), 64'(imm1), 64'(vecs[k].e32));
            chk($sformatf("vec%0d x32 illegal", k), 64'(ill1), 64'(vecs[k].i32));
            chk($sformatf("vec%0d tag", k), 64'(tag0), 64'(k + 1));
            step();
        end

        // Backpressure: tags 1,2,3 with output stalled for three cycles
        for (int d = 0; d < 3; d++) out_ready_a[d] = 1'b0;
        in_valid = 1'b1;
        op       = 3'd1;
        inst     = 32'h0010_0093;
        tag      = 8'd1;
        step();
        tag = 8'd2;
        step();
        tag = 8'd3;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp held tag", 64'(tag0), 64'd1);
            chk("bp in_ready low", 64'(rdy0), 64'd0);
            step();
        end
        for (int d = 0; d < 3; d++) out_ready_a[d] = 1'b1;
        for (int c = 0; c < 12 && got.size() < 3; c++) begin
            @(negedge clk);
            if (vld0) got.push_back(tag0);
            drop = in_valid && rdy0;
            step();
            if (drop) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("bp tag count", 64'(got.size()), 64'd3);
        for (int k = 0; k < 3 && k < got.size(); k++)
            chk($sformatf("bp order %0d", k), 64'(got[k]), 64'(k + 1));
        repeat (3) step();

        // Simultaneous take and accept every cycle
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tag  = 8'(8'h40 + i);
            inst = $urandom;
            op   = 3'($urandom_range(0, 7));
            @(posedge clk);
            @(negedge clk);
            chk("stream out_valid", 64'(vld0), 64'd1);
            chk("stream tag", 64'(tag0), 64'(8'h40 + i));
        end
        in_valid = 1'b0;
        repeat (3) step();

        // Reset with skid full and output stalled
        for (int d = 0; d < 3; d++) out_ready_a[d] = 1'b0;
        in_valid = 1'b1;
        tag      = 8'hA1;
        step();
        tag = 8'hA2;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre-reset skid full", 64'(rdy0), 64'd0);
        chk("pre-reset out_tag", 64'(tag0), 64'hA1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d midrst out_valid", d), 64'(out_valid_a[d]), 64'd0);
            chk($sformatf("d%0d midrst imm", d), imm_a[d], 64'd0);
            chk($sformatf("d%0d midrst out_tag", d), 64'(tag_a[d]), 64'd0);
            chk($sformatf("d%0d midrst in_ready", d), 64'(in_ready_a[d]), 64'd1);
        end
        for (int d = 0; d < 3; d++) out_ready_a[d] = 1'b1;
        repeat (4) step();

        // Randomised traffic with independent downstream readiness per instance
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 99) < 70);
            inst     = $urandom;
            op       = 3'($urandom_range(0, 7));
            tag      = 8'($urandom);
            for (int d = 0; d < 3; d++) out_ready_a[d] = ($urandom_range(0, 99) < 60);
            step();
        end
        in_valid = 1'b0;
        for (int d = 0; d < 3; d++) out_ready_a[d] = 1'b1;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
